// File: rtl/pea_pkg.sv
// Shared PE constants and types for the functional units.
// Holds the multiplier FSM encoding and the default radix/stage counts.
package pea_pkg;

    localparam int N_BITS      = 32;
    localparam int N_RADIX     = 4;
    localparam int LOG2_RADIX  = $clog2(N_RADIX);
    localparam int N_MUL_STAGE = N_BITS / LOG2_RADIX;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mul_fsm_t;

endpackage

// File: rtl/r_mul_stage.sv
// One radix digit step of the shift-add multiplier.
// Adds digit*mag_b to the upper accumulator half; the result is one radix digit wider.
module r_mul_stage
    import pea_pkg::*;
#(
    parameter int N_BITS  = pea_pkg::N_BITS,
    parameter int N_RADIX = pea_pkg::N_RADIX
) (
    input  logic [$clog2(N_RADIX)-1:0]        digit,
    input  logic [N_BITS-1:0]                 mag_b,
    input  logic [N_BITS-1:0]                 acc_hi,
    output logic [N_BITS+$clog2(N_RADIX)-1:0] sum
);

    localparam int LG = $clog2(N_RADIX);

    // Partial product plus running upper half; digit < N_RADIX so the sum cannot overflow N_BITS+LG bits.
    always_comb begin
        sum = ({{LG{1'b0}}, mag_b} * {{N_BITS{1'b0}}, digit}) + {{LG{1'b0}}, acc_hi};
    end

endmodule

// File: rtl/r_mul.sv
// Multicycle radix-configurable shift-add multiplier for the PE.
// Retires log2(N_RADIX) multiplier bits per EXEC cycle and returns the full 2*N_BITS product.
// Build option: R_MUL_SIGNED_EN selects two's complement operands; otherwise operands are unsigned.
module r_mul
    import pea_pkg::*;
#(
    parameter int N_BITS  = pea_pkg::N_BITS,
    parameter int N_RADIX = pea_pkg::N_RADIX
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  clear_i,
    input  logic [N_BITS-1:0]     a_i,
    input  logic [N_BITS-1:0]     b_i,
    output logic [2*N_BITS-1:0]   p_o,
    output logic                  busy_o,
    output logic                  valid_o
);

    localparam int LG      = $clog2(N_RADIX);
    localparam int N_STAGE = N_BITS / LG;
    localparam int CNT_W   = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_STAGE - 1);

    mul_fsm_t state;
    mul_fsm_t next_state;

    logic [CNT_W-1:0]      cnt;
    logic [2*N_BITS-1:0]   acc;
    logic [N_BITS-1:0]     mag_a;
    logic [N_BITS-1:0]     mag_b;
    logic                  neg;

    logic [N_BITS-1:0]     in_mag_a;
    logic [N_BITS-1:0]     in_mag_b;
    logic                  in_neg;
    logic                  accept;
    logic [N_BITS+LG-1:0]  stage_sum;

    assign accept = start_i && !clear_i && ((state == IDLE) || (state == DONE));

`ifdef R_MUL_SIGNED_EN
    // Operand magnitudes and result sign; the most negative value maps to its unsigned magnitude.
    always_comb begin
        in_mag_a = a_i[N_BITS-1] ? ((~a_i) + N_BITS'(1)) : a_i;
        in_mag_b = b_i[N_BITS-1] ? ((~b_i) + N_BITS'(1)) : b_i;
        in_neg   = a_i[N_BITS-1] ^ b_i[N_BITS-1];
    end
`else
    // Unsigned operands pass straight through and the result is never negated.
    always_comb begin
        in_mag_a = a_i;
        in_mag_b = b_i;
        in_neg   = 1'b0;
    end
`endif

    r_mul_stage #(
        .N_BITS  (N_BITS),
        .N_RADIX (N_RADIX)
    ) u_stage (
        .digit  (mag_a[LG-1:0]),
        .mag_b  (mag_b),
        .acc_hi (acc[2*N_BITS-1:N_BITS]),
        .sum    (stage_sum)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; clear overrides everything, start is only honoured in IDLE or DONE.
    always_comb begin
        next_state = state;
        if (clear_i) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    next_state = start_i ? EXEC : IDLE;
                EXEC:    next_state = (cnt == CNT_LAST) ? FIX : EXEC;
                FIX:     next_state = DONE;
                DONE:    next_state = start_i ? EXEC : IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy_o  = (state == EXEC) || (state == FIX);
        valid_o = (state == DONE);
    end

    // Datapath: operand capture, one digit per EXEC cycle, sign fix-up into p_o during FIX.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt   <= '0;
            acc   <= '0;
            mag_a <= '0;
            mag_b <= '0;
            neg   <= 1'b0;
            p_o   <= '0;
        end else if (clear_i) begin
            cnt <= '0;
            acc <= '0;
        end else if (accept) begin
            mag_a <= in_mag_a;
            mag_b <= in_mag_b;
            neg   <= in_neg;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            case (state)
                EXEC: begin
                    acc   <= {stage_sum, acc[N_BITS-1:LG]};
                    mag_a <= mag_a >> LG;
                    cnt   <= cnt + CNT_W'(1);
                end
                FIX: begin
                    p_o <= neg ? ((~acc) + (2*N_BITS)'(1)) : acc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_r_mul.sv
// Self-checking bench for r_mul (N_BITS=32, N_RADIX=4).
// Stimulus pushes expected products into a queue; a monitor pops and compares on every valid.
// Build option: R_MUL_SIGNED_EN switches the reference model to signed arithmetic.
module tb_r_mul;

    localparam int NB     = 32;
    localparam int NR     = 4;
    localparam int NSTAGE = 16;
    localparam int LAT    = NSTAGE + 1;

    logic            clk_i;
    logic            rst_i;
    logic            start_i;
    logic            clear_i;
    logic [NB-1:0]   a_i;
    logic [NB-1:0]   b_i;
    logic [2*NB-1:0] p_o;
    logic            busy_o;
    logic            valid_o;

    typedef struct {
        logic [63:0] prod;
        int          accept_cycle;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [63:0] last_prod = '0;

    r_mul #(
        .N_BITS  (NB),
        .N_RADIX (NR)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .clear_i (clear_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .p_o     (p_o),
        .busy_o  (busy_o),
        .valid_o (valid_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Count rising edges so acceptance and valid can be placed on a common time axis.
    always @(posedge clk_i) cyc <= cyc + 1;

    // Reference product computed directly with wide integer arithmetic.
    function automatic logic [63:0] modelProduct(input logic [31:0] a, input logic [31:0] b);
`ifdef R_MUL_SIGNED_EN
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
`else
        logic [63:0] ua;
        logic [63:0] ub;
        ua = {32'd0, a};
        ub = {32'd0, b};
        return ua * ub;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", name, actual, expected);
        end
    endtask

    // Called at a falling edge; the start pulse is accepted at the following rising edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit expect_result,
                                 input string tag);
        exp_t e;
        start_i = 1'b1;
        a_i     = a;
        b_i     = b;
        if (expect_result) begin
            e.prod         = modelProduct(a, b);
            e.accept_cycle = cyc + 1;
            e.tag          = tag;
            exp_q.push_back(e);
        end
        @(negedge clk_i);
        start_i = 1'b0;
        a_i     = $urandom;
        b_i     = $urandom;
    endtask

    task automatic waitDrain(input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(negedge clk_i);
            n++;
        end
        if (exp_q.size() != 0) begin
            checkOutput("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    task automatic waitValid(input int max_cycles);
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (valid_o !== 1'b1 && n < max_cycles);
        if (valid_o !== 1'b1) checkOutput("valid_timeout", 64'(valid_o), 64'd1);
    endtask

    // Monitor: every valid must match the oldest outstanding expectation, on time.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (valid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_valid", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput({e.tag, "_product"}, p_o, e.prod);
                    checkOutput({e.tag, "_latency"}, 64'(cyc), 64'(e.accept_cycle + LAT));
                    checkOutput({e.tag, "_busy_in_done"}, 64'(busy_o), 64'd0);
                    last_prod = e.prod;
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] da[6];
        logic [31:0] db[6];

        rst_i   = 1'b1;
        start_i = 1'b0;
        clear_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        repeat (3) @(negedge clk_i);
        checkOutput("reset_p", p_o, 64'd0);
        checkOutput("reset_busy", 64'(busy_o), 64'd0);
        checkOutput("reset_valid", 64'(valid_o), 64'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Directed operands including sign and width corners.
        da = '{32'd7, 32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
        db = '{32'd6, 32'd5, 32'h8000_0000, 32'd1, 32'h1234_5678, 32'hFFFF_FFFF};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(da[i], db[i], 1'b1, $sformatf("directed%0d", i));
            waitDrain(LAT + 5);
            if (i == 0) checkOutput("plan_7x6", p_o, 64'h0000_0000_0000_002A);
`ifdef R_MUL_SIGNED_EN
            if (i == 1) checkOutput("plan_neg3x5", p_o, 64'hFFFF_FFFF_FFFF_FFF1);
            if (i == 2) checkOutput("plan_min_sq", p_o, 64'h4000_0000_0000_0000);
            if (i == 3) checkOutput("plan_min_x1", p_o, 64'hFFFF_FFFF_8000_0000);
`else
            if (i == 1) checkOutput("plan_fffffffd_x5", p_o, 64'h0000_0004_FFFF_FFF1);
`endif
        end

        // Back-to-back: second start issued while the first result is in DONE.
        applyStimulus(32'd3, 32'd4, 1'b1, "b2b_first");
        waitValid(LAT + 5);
        checkOutput("b2b_first_value", p_o, 64'd12);
        applyStimulus(32'd0, 32'd9, 1'b1, "b2b_second");
        waitDrain(LAT + 5);
        checkOutput("b2b_second_value", p_o, 64'd0);

        // Start during EXEC must be ignored.
        applyStimulus(32'h0000_1234, 32'h0000_5678, 1'b1, "ignore_start");
        repeat (5) @(negedge clk_i);
        start_i = 1'b1;
        a_i     = 32'hCAFE_F00D;
        b_i     = 32'h0BAD_BEEF;
        @(negedge clk_i);
        start_i = 1'b0;
        checkOutput("ignore_busy", 64'(busy_o), 64'd1);
        waitDrain(LAT + 5);

        // Clear mid-EXEC: back to IDLE, no valid, product register untouched.
        applyStimulus(32'h0000_DEAD, 32'h0000_BEEF, 1'b0, "clear");
        repeat (8) @(negedge clk_i);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        checkOutput("clear_busy", 64'(busy_o), 64'd0);
        checkOutput("clear_valid", 64'(valid_o), 64'd0);
        checkOutput("clear_p_held", p_o, last_prod);
        repeat (LAT + 4) @(negedge clk_i);
        checkOutput("clear_p_still_held", p_o, last_prod);

        // Reset during FIX: everything returns to reset values at once.
        applyStimulus(32'h0000_0055, 32'h0000_0077, 1'b0, "reset_fix");
        repeat (NSTAGE) @(negedge clk_i);
        checkOutput("fix_busy", 64'(busy_o), 64'd1);
        rst_i = 1'b1;
        #1;
        checkOutput("rst_fix_p", p_o, 64'd0);
        checkOutput("rst_fix_busy", 64'(busy_o), 64'd0);
        checkOutput("rst_fix_valid", 64'(valid_o), 64'd0);
        last_prod = '0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        applyStimulus(32'd1000, 32'd1000, 1'b1, "after_reset");
        waitDrain(LAT + 5);

        // Randomized operands with corner biasing, mixing back-to-back and idle gaps.
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 7))
                0:       ra = 32'd0;
                1:       ra = 32'h8000_0000;
                2:       ra = 32'hFFFF_FFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       rb = 32'd1;
                1:       rb = 32'h7FFF_FFFF;
                default: rb = $urandom;
            endcase
            applyStimulus(ra, rb, 1'b1, $sformatf("random%0d", i));
            waitValid(LAT + 5);
            if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk_i);
        end
        waitDrain(LAT + 5);
        repeat (3) @(negedge clk_i);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
